// File: rtl/sp_shiftreg_hs.sv
// rtl/sp_shiftreg_hs.sv - serial-to-parallel word assembler with ready/valid on both sides
// Packs M chunks of N bits into one word, supports early flush of a partial word and back-pressure.
module sp_shiftreg_hs #(
    parameter int N         = 4,
    parameter int M         = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             sin,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [M*N-1:0]           q,
    output logic [$clog2(M+1)-1:0]   out_count
);

    localparam int W  = M * N;
    localparam int CW = $clog2(M + 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [W-1:0]    r_q;

    logic            w_accept;
    logic [CW-1:0]   w_fill_count;
    logic [W-1:0]    w_fill_q;
    logic            w_close;

    function automatic logic [W-1:0] shift_in(input logic [W-1:0] base,
                                              input logic [N-1:0] chunk);
        if (MSB_FIRST != 0)
            return {base[W-N-1:0], chunk};
        else
            return {chunk, base[W-1:N]};
    endfunction

    // While a word is held, the only way a chunk gets in is alongside a take.
    assign in_ready  = (r_state == FULL) ? out_ready : 1'b1;
    assign out_valid = (r_state == FULL);
    assign q         = r_q;
    assign out_count = (r_state == FULL) ? r_count : '0;

    always_comb begin
        w_accept     = in_valid && in_ready;
        w_fill_count = r_count + {{(CW-1){1'b0}}, w_accept};
        w_fill_q     = w_accept ? shift_in(r_q, sin) : r_q;
        w_close      = (w_fill_count == CW'(M)) || (flush && (w_fill_count != '0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FILL;
            r_count <= '0;
            r_q     <= '0;
        end else if (clr) begin
            r_state <= FILL;
            r_count <= '0;
            r_q     <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    r_q     <= w_fill_q;
                    r_count <= w_fill_count;
                    if (w_close)
                        r_state <= FULL;
                end
                FULL: begin
                    if (out_ready) begin
                        r_state <= FILL;
                        if (in_valid) begin
                            r_q     <= shift_in('0, sin);
                            r_count <= CW'(1);
                        end else begin
                            r_q     <= '0;
                            r_count <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_count <= '0;
                    r_q     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sp_shiftreg_hs.sv
// tb/tb_sp_shiftreg_hs.sv - directed and soak bench for sp_shiftreg_hs
// Runs an MSB_FIRST=1 and an MSB_FIRST=0 instance side by side on the same stimulus.
module tb_sp_shiftreg_hs;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        in_valid;
    logic [3:0]  sin;
    logic        flush;
    logic        out_ready;

    logic        m_in_ready, m_out_valid;
    logic [15:0] m_q;
    logic [2:0]  m_out_count;
    logic        l_in_ready, l_out_valid;
    logic [15:0] l_q;
    logic [2:0]  l_out_count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    sp_shiftreg_hs #(.N(4), .M(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(m_in_ready),
        .sin(sin), .flush(flush), .out_valid(m_out_valid), .out_ready(out_ready),
        .q(m_q), .out_count(m_out_count)
    );

    sp_shiftreg_hs #(.N(4), .M(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(l_in_ready),
        .sin(sin), .flush(flush), .out_valid(l_out_valid), .out_ready(out_ready),
        .q(l_q), .out_count(l_out_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [3:0] s, input logic fl,
                         input logic ordy, input logic cl);
        in_valid  = iv;
        sin       = s;
        flush     = fl;
        out_ready = ordy;
        clr       = cl;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        #3;
        vectors++; if (m_q !== 16'h0) begin errors++; $display("FAIL reset_q_msb: got %h want 0000", m_q); end
        vectors++; if (l_q !== 16'h0) begin errors++; $display("FAIL reset_q_lsb: got %h want 0000", l_q); end
        vectors++; if (m_out_valid !== 1'b0 || l_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b/%b want 0/0", m_out_valid, l_out_valid); end
        vectors++; if (m_out_count !== 3'd0) begin errors++; $display("FAIL reset_out_count: got %0d want 0", m_out_count); end
        vectors++; if (m_in_ready !== 1'b1 || l_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b/%b want 1/1", m_in_ready, l_in_ready); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fill_and_hold();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        vectors++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL fill_out_valid: got %b want 1", m_out_valid); end
        vectors++; if (m_q !== 16'h1234) begin errors++; $display("FAIL fill_q_msb: got %h want 1234", m_q); end
        vectors++; if (l_q !== 16'h4321) begin errors++; $display("FAIL fill_q_lsb: got %h want 4321", l_q); end
        vectors++; if (m_out_count !== 3'd4 || l_out_count !== 3'd4) begin errors++; $display("FAIL fill_out_count: got %0d/%0d want 4/4", m_out_count, l_out_count); end
        vectors++; if (m_in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", m_in_ready); end
        drive(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        vectors++; if (m_q !== 16'h1234 || m_out_valid !== 1'b1) begin errors++; $display("FAIL hold_q_msb: got %h/%b want 1234/1", m_q, m_out_valid); end
        vectors++; if (l_q !== 16'h4321) begin errors++; $display("FAIL hold_q_lsb: got %h want 4321", l_q); end
        drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        #1;
        vectors++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL take_in_ready_pass: got %b want 1", m_in_ready); end
        tick();
        vectors++; if (m_out_valid !== 1'b0 || l_out_valid !== 1'b0) begin errors++; $display("FAIL take_out_valid: got %b/%b want 0/0", m_out_valid, l_out_valid); end
        vectors++; if (m_q !== 16'h0 || l_q !== 16'h0) begin errors++; $display("FAIL take_q: got %h/%h want 0000/0000", m_q, l_q); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 4'(i), 1'b0, 1'b1, 1'b0);
            #1;
            vectors++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d: got %b want 1", i, m_in_ready); end
            tick();
            if (i == 4) begin
                vectors++; if (m_q !== 16'h1234 || m_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_word1_msb: got %h/%b want 1234/1", m_q, m_out_valid); end
                vectors++; if (l_q !== 16'h4321) begin errors++; $display("FAIL b2b_word1_lsb: got %h want 4321", l_q); end
            end
            if (i == 5) begin
                vectors++; if (m_q !== 16'h0005 || l_q !== 16'h5000 || m_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_restart: got %h/%h/%b want 0005/5000/0", m_q, l_q, m_out_valid); end
            end
            if (i == 8) begin
                vectors++; if (m_q !== 16'h5678 || m_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_word2_msb: got %h/%b want 5678/1", m_q, m_out_valid); end
                vectors++; if (l_q !== 16'h8765) begin errors++; $display("FAIL b2b_word2_lsb: got %h want 8765", l_q); end
            end
        end
        drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 4'hA, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 4'hB, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 4'hC, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        vectors++; if (m_out_valid !== 1'b1 || m_out_count !== 3'd3) begin errors++; $display("FAIL flush3_valid_count: got %b/%0d want 1/3", m_out_valid, m_out_count); end
        vectors++; if (m_q !== 16'h0ABC) begin errors++; $display("FAIL flush3_q_msb: got %h want 0abc", m_q); end
        vectors++; if (l_q !== 16'hCBA0 || l_out_count !== 3'd3) begin errors++; $display("FAIL flush3_q_lsb: got %h/%0d want cba0/3", l_q, l_out_count); end
        drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0); tick(); tick();
        vectors++; if (m_out_valid !== 1'b0 || m_out_count !== 3'd0) begin errors++; $display("FAIL flush_empty: got %b/%0d want 0/0", m_out_valid, m_out_count); end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), (i == 4), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++; if (m_q !== 16'h1234 || m_out_count !== 3'd4) begin errors++; $display("FAIL flush_full_word: got %h/%0d want 1234/4", m_q, m_out_count); end
        drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0); tick();
    endtask

    task automatic test_clr();
        drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
        #1;
        vectors++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL clr_in_ready: got %b want 1", m_in_ready); end
        tick();
        vectors++; if (m_q !== 16'h0 || l_q !== 16'h0 || m_out_valid !== 1'b0) begin errors++; $display("FAIL clr_q: got %h/%h/%b want 0000/0000/0", m_q, l_q, m_out_valid); end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        vectors++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL clr_count_cleared: got %b want 0", m_out_valid); end
        drive(1'b1, 4'h4, 1'b0, 1'b0, 1'b0); tick();
        vectors++; if (m_q !== 16'h1234 || l_q !== 16'h4321 || m_out_valid !== 1'b1) begin errors++; $display("FAIL clr_clean_word: got %h/%h/%b want 1234/4321/1", m_q, l_q, m_out_valid); end
        drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0); tick();
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        vectors++; if (m_q !== 16'h1234 || m_out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got %h/%b want 1234/1", m_q, m_out_valid); end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (m_q !== 16'h0 || l_q !== 16'h0) begin errors++; $display("FAIL areset_q: got %h/%h want 0000/0000", m_q, l_q); end
        vectors++; if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_out_count !== 3'd0) begin errors++; $display("FAIL areset_ctrl: got v=%b r=%b c=%0d want 0/1/0", m_out_valid, m_in_ready, m_out_count); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_soak();
        logic [3:0]  pend[$];
        logic [15:0] exp_m[$];
        logic [15:0] exp_l[$];
        logic [2:0]  exp_k[$];
        logic        full, exp_ir, acc, take;
        logic [15:0] wm, wl, tmp;
        int          k;
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (cyc < 400)
                drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'b0);
            else
                drive(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
            #1;
            full   = (exp_k.size() != 0);
            exp_ir = full ? out_ready : 1'b1;
            vectors++; if (m_out_valid !== full || l_out_valid !== full) begin errors++; $display("FAIL soak_valid c%0d: got %b/%b want %b", cyc, m_out_valid, l_out_valid, full); end
            vectors++; if (m_in_ready !== exp_ir || l_in_ready !== exp_ir) begin errors++; $display("FAIL soak_in_ready c%0d: got %b/%b want %b", cyc, m_in_ready, l_in_ready, exp_ir); end
            acc  = in_valid && exp_ir;
            take = full && out_ready;
            if (take) begin
                vectors++; if (m_q !== exp_m[0] || m_out_count !== exp_k[0]) begin errors++; $display("FAIL soak_word_msb c%0d: got %h/%0d want %h/%0d", cyc, m_q, m_out_count, exp_m[0], exp_k[0]); end
                vectors++; if (l_q !== exp_l[0] || l_out_count !== exp_k[0]) begin errors++; $display("FAIL soak_word_lsb c%0d: got %h/%0d want %h/%0d", cyc, l_q, l_out_count, exp_l[0], exp_k[0]); end
                void'(exp_m.pop_front());
                void'(exp_l.pop_front());
                void'(exp_k.pop_front());
                if (acc) pend.push_back(sin);
            end else if (!full) begin
                if (acc) pend.push_back(sin);
                if (pend.size() == 4 || (flush && pend.size() != 0)) begin
                    k  = pend.size();
                    wm = '0;
                    wl = '0;
                    for (int i = 0; i < k; i++) begin
                        tmp = {12'h000, pend[i]};
                        wm  = wm | (tmp << ((k - 1 - i) * 4));
                        wl  = wl | (tmp << ((4 - k + i) * 4));
                    end
                    exp_m.push_back(wm);
                    exp_l.push_back(wl);
                    exp_k.push_back(3'(k));
                    pend.delete();
                end
            end
            tick();
        end
        vectors++; if (exp_k.size() != 0 || pend.size() != 0) begin errors++; $display("FAIL soak_drain: got %0d words %0d chunks left want 0/0", exp_k.size(), pend.size()); end
    endtask

    initial begin
        test_reset();
        test_fill_and_hold();
        test_back_to_back();
        test_flush();
        test_clr();
        test_async_reset();
        test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
